// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   // Canonical RV32I NOP: addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   // Word-step increment of a PC, wrapping modulo 2^32.
   function automatic logic [31:0] pc_step(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {instr, pc, pc_plus4} while decode is stalled.
// Flush wins over load, load wins over unload.
module fetch_skid_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic                  unload_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [ADDR_WIDTH-1:0] pc_plus4_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

   // Next-state selection for the buffered entry.
   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d    = 1'b1;
         instr_d    = instr_i;
         pc_d       = pc_i;
         pc_plus4_d = pc_plus4_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry storage with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         pc_plus4_q <= '0;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid_o    = valid_q;
   assign instr_o    = instr_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC ownership, imem req/valid handshake with wait
// states, IF/ID output register backed by a one-entry skid buffer, stall and redirect.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  PCSrc,
   input  logic [ADDR_WIDTH-1:0] branch_pc,
   input  logic [31:0]           ImmExt,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  imem_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic [ADDR_WIDTH-1:0] pc_plus4
);

   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] drain_addr_q, drain_addr_d;   // address held on the bus while draining
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
   logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] target;
   logic                  skid_load, skid_unload, skid_flush;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_instr;
   logic [ADDR_WIDTH-1:0] skid_pc, skid_pc_plus4;

   assign pc_next = pc_q + ADDR_WIDTH'(4);
   assign target  = branch_pc + ADDR_WIDTH'($signed(ImmExt));

   fetch_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_skid (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (skid_load),
      .unload_i   (skid_unload),
      .flush_i    (skid_flush),
      .instr_i    (imem_rdata),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_next),
      .valid_o    (skid_valid),
      .instr_o    (skid_instr),
      .pc_o       (skid_pc),
      .pc_plus4_o (skid_pc_plus4)
   );

   // Next-state, PC update, output-register and skid control; redirect has top priority.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      out_valid_d  = out_valid_q & stall;   // entry consumed when not stalled
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      pc_plus4_d   = pc_plus4_q;
      skid_load    = 1'b0;
      skid_unload  = 1'b0;
      skid_flush   = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (PCSrc) begin
               pc_d        = target;
               out_valid_d = 1'b0;
               skid_flush  = 1'b1;
               if (imem_valid) begin
                  state_d = FETCH;
               end else begin
                  state_d      = DRAIN;
                  drain_addr_d = pc_q;
               end
            end else if (imem_valid) begin
               pc_d = pc_next;
               if (!out_valid_q || !stall) begin
                  out_valid_d = 1'b1;
                  instr_d     = imem_rdata;
                  pc_out_d    = pc_q;
                  pc_plus4_d  = pc_next;
               end else begin
                  skid_load = 1'b1;
                  state_d   = HOLD;
               end
            end else begin
               state_d = FETCH;
            end
         end
         HOLD: begin
            if (PCSrc) begin
               pc_d        = target;
               out_valid_d = 1'b0;
               skid_flush  = 1'b1;
               state_d     = FETCH;
            end else if (!stall) begin
               skid_unload = 1'b1;
               out_valid_d = skid_valid;
               instr_d     = skid_instr;
               pc_out_d    = skid_pc;
               pc_plus4_d  = skid_pc_plus4;
               state_d     = FETCH;
            end else begin
               state_d = HOLD;
            end
         end
         DRAIN: begin
            if (PCSrc) begin
               pc_d        = target;
               out_valid_d = 1'b0;
               skid_flush  = 1'b1;
               state_d     = DRAIN;
            end else if (imem_valid) begin
               state_d = FETCH;   // stale response dropped
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            skid_flush  = 1'b1;
         end
      endcase
      if (!out_valid_d) begin
         instr_d = NOP;
      end else begin
         instr_d = instr_d;
      end
   end

   // State, PC and IF/ID output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_VECTOR;
         drain_addr_q <= RESET_VECTOR;
         out_valid_q  <= 1'b0;
         instr_q      <= NOP;
         pc_out_q     <= '0;
         pc_plus4_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         out_valid_q  <= out_valid_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

   assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
   assign instr       = instr_q;
   assign instr_valid = out_valid_q;
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, zero-wait streaming, stall/HOLD,
// redirect from HOLD under stall, 2-wait-state memory with DRAIN, and PC wrap-around.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall, pcsrc;
   logic [31:0] branch_pc, imm_ext;
   logic        imem_req, imem_valid, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4;
   logic [3:0]  wait_states, wcnt;

   logic        req2, valid2;
   logic [31:0] addr2, instr2, pc_out2, pc4_2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_stage u_dut (
      .clk(clk), .rst(rst), .stall(stall), .PCSrc(pcsrc),
      .branch_pc(branch_pc), .ImmExt(imm_ext),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .instr(instr), .instr_valid(instr_valid),
      .pc_out(pc_out), .pc_plus4(pc_plus4)
   );

   fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_wrap (
      .clk(clk), .rst(rst), .stall(1'b0), .PCSrc(1'b0),
      .branch_pc(32'd0), .ImmExt(32'd0),
      .imem_req(req2), .imem_addr(addr2),
      .imem_rdata(addr2), .imem_valid(req2),
      .instr(instr2), .instr_valid(valid2),
      .pc_out(pc_out2), .pc_plus4(pc4_2)
   );

   // Memory model: mem[a] = a, answers after wait_states cycles of a held request.
   assign imem_valid = imem_req && (wcnt == wait_states);
   assign imem_rdata = imem_addr;
   always @(posedge clk) begin
      if (!imem_req || imem_valid) wcnt <= 4'd0;
      else                         wcnt <= wcnt + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic out_chk(input string tag, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_pc"},    pc_out,   pc);
      chk({tag, "_pc4"},   pc_plus4, pc + 32'd4);
      chk({tag, "_instr"}, instr,    pc);
   endtask

   task automatic empty_chk(input string tag);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_nop"},   instr, 32'h0000_0013);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; pcsrc = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; pcsrc = 1'b0;
      branch_pc = 32'd0; imm_ext = 32'd0; wait_states = 4'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req",    {31'd0, imem_req}, 32'd0);
      chk("rst_addr",   imem_addr, 32'd0);
      empty_chk("rst");
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_pc4",    pc_plus4, 32'd0);
      chk("rst_addr2",  addr2, 32'hFFFF_FFF8);
      rst = 1'b0;

      // Edge 1: FETCH at reset vector, nothing valid yet
      @(negedge clk);
      chk("e1_req",  {31'd0, imem_req}, 32'd1);
      chk("e1_addr", imem_addr, 32'd0);
      empty_chk("e1");
      // Edge 2 onward: one instruction per cycle; wrap instance crosses 0
      @(negedge clk);
      out_chk("s0", 32'd0);
      chk("wrap0", pc_out2, 32'hFFFF_FFF8);
      @(negedge clk);
      out_chk("s4", 32'd4);
      chk("wrap1", pc_out2, 32'hFFFF_FFFC);
      chk("s4_addr", imem_addr, 32'd8);
      stall = 1'b1;
      // Response for 8 arrives under stall: HOLD, output keeps pc 4
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_chk("hold", 32'd4);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
         if (i == 0) chk("wrap2", pc_out2, 32'd0);
      end
      stall = 1'b0;
      @(negedge clk);
      out_chk("rel8", 32'd8);
      chk("rel_addr", imem_addr, 32'd12);
      @(negedge clk);
      out_chk("rel12", 32'd12);

      // Redirect while in HOLD with stall also high: target 0x100 + 0x40
      stall = 1'b1;
      @(negedge clk);
      chk("h2_req", {31'd0, imem_req}, 32'd0);
      out_chk("h2", 32'd12);
      pcsrc = 1'b1; branch_pc = 32'h100; imm_ext = 32'h40;
      @(negedge clk);
      pcsrc = 1'b0; stall = 1'b0;
      empty_chk("hr");
      chk("hr_addr", imem_addr, 32'h140);
      chk("hr_req",  {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      out_chk("hr_t0", 32'h140);
      @(negedge clk);
      out_chk("hr_t1", 32'h144);

      // 2-wait-state memory: one instruction every 3 cycles, address held
      wait_states = 4'd2;
      do_reset();
      for (int e = 1; e <= 26; e++) begin
         @(negedge clk);
         chk("ws_req",  {31'd0, imem_req}, 32'd1);
         chk("ws_addr", imem_addr, 32'(4 * ((e - 1) / 3)));
         if (e >= 4 && (e % 3) == 1) out_chk("ws", 32'(4 * ((e - 4) / 3)));
         else                        empty_chk("ws");
      end

      // Redirect to 0x10 - 8 while the request to 0x20 is pending
      pcsrc = 1'b1; branch_pc = 32'h10; imm_ext = 32'hFFFF_FFF8;
      @(negedge clk);
      pcsrc = 1'b0;
      empty_chk("dr0");
      chk("dr0_req",  {31'd0, imem_req}, 32'd1);
      chk("dr0_addr", imem_addr, 32'h20);
      @(negedge clk);
      empty_chk("dr1");
      chk("dr1_addr", imem_addr, 32'h08);
      repeat (2) begin
         @(negedge clk);
         empty_chk("dr_w");
      end
      @(negedge clk);
      out_chk("dr_tgt", 32'h08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
